// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide controller:
// MDOp codes, FSM state encoding, busy-counter width and op helpers.
package md_pkg;

  localparam int CNT_W = 4;

  localparam logic [3:0] MD_NONE  = 4'd0;
  localparam logic [3:0] MD_MULT  = 4'd1;
  localparam logic [3:0] MD_MULTU = 4'd2;
  localparam logic [3:0] MD_DIV   = 4'd3;
  localparam logic [3:0] MD_DIVU  = 4'd4;
  localparam logic [3:0] MD_MTHI  = 4'd5;
  localparam logic [3:0] MD_MTLO  = 4'd6;
  localparam logic [3:0] MD_MFHI  = 4'd7;
  localparam logic [3:0] MD_MFLO  = 4'd8;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } md_state_e;

  // Ops that occupy the unit for a multi-cycle window.
  function automatic logic is_arith(
    input logic [3:0] op
  );
    return (op >= MD_MULT) && (op <= MD_DIVU);
  endfunction

  function automatic logic is_div(
    input logic [3:0] op
  );
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  // Any valid MDOp (1..8); 9..15 behave as none.
  function automatic logic is_md(
    input logic [3:0] op
  );
    return (op >= MD_MULT) && (op <= MD_MFLO);
  endfunction

endpackage

// File: rtl/md_arith.sv
// Combinational mult/multu/div/divu datapath.
// Ports: op, a, b in; res = {hi,lo} result, div0 = divide by zero.
module md_arith
  import md_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [63:0] res,
  output logic        div0
);

  logic               ovf;
  logic               bz;
  logic [31:0]        bs;
  logic signed [63:0] smul;
  logic [63:0]        umul;
  logic signed [31:0] sq;
  logic signed [31:0] sr;
  logic [31:0]        uq;
  logic [31:0]        ur;

  assign bz  = (b == 32'd0);
  assign ovf = (a == 32'h8000_0000) &&
               (b == 32'hFFFF_FFFF);

  // Substitute divisor 1 for /0 and for the
  // INT_MIN/-1 case: the first result is
  // discarded, the second becomes exactly
  // q=INT_MIN, r=0 without a divider overflow.
  assign bs = (bz || ovf) ? 32'd1 : b;

  assign smul = $signed({{32{a[31]}}, a}) *
                $signed({{32{b[31]}}, b});
  assign umul = {32'd0, a} * {32'd0, b};

  assign sq = $signed(a) / $signed(bs);
  assign sr = $signed(a) % $signed(bs);
  assign uq = a / bs;
  assign ur = a % bs;

  always_comb begin
    res  = '0;
    div0 = 1'b0;
    unique case (1'b1)
      (op == MD_MULT):  res = smul;
      (op == MD_MULTU): res = umul;
      (op == MD_DIV): begin
        res  = {sr, sq};
        div0 = bz;
      end
      (op == MD_DIVU): begin
        res  = {ur, uq};
        div0 = bz;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/md_ctrl.sv
// E-stage multiply/divide controller: owns HI/LO, models busy window.
// Ports: clk, reset(n), E_MDOp/E_A/E_B, D_is_md; start, busy, stall_md, E_MDout, hi, lo.
module md_ctrl
  import md_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  E_MDOp,
  input  logic [31:0] E_A,
  input  logic [31:0] E_B,
  input  logic        D_is_md,
  output logic        start,
  output logic        busy,
  output logic        stall_md,
  output logic [31:0] E_MDout,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [CNT_W-1:0] MULT_N =
    CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_N =
    CNT_W'(DIV_CYCLES);

  md_state_e        state, state_n;
  logic [CNT_W-1:0] count, count_n;
  logic             busy_n;
  logic [31:0]      hi_n, lo_n;
  logic [31:0]      pend_hi, pend_hi_n;
  logic [31:0]      pend_lo, pend_lo_n;
  logic             pend_keep, pend_keep_n;

  logic [63:0]      res;
  logic             div0;

  md_arith u_arith (
    .op   (E_MDOp),
    .a    (E_A),
    .b    (E_B),
    .res  (res),
    .div0 (div0)
  );

  assign start    = is_arith(E_MDOp) &&
                    (state == ST_IDLE);
  assign stall_md = D_is_md && (start || busy);

  always_comb begin
    E_MDout = '0;
    unique case (1'b1)
      (E_MDOp == MD_MFHI): E_MDout = hi;
      (E_MDOp == MD_MFLO): E_MDout = lo;
      default: ;
    endcase
  end

  always_comb begin
    state_n     = state;
    count_n     = count;
    busy_n      = busy;
    hi_n        = hi;
    lo_n        = lo;
    pend_hi_n   = pend_hi;
    pend_lo_n   = pend_lo;
    pend_keep_n = pend_keep;
    unique case (state)
      ST_IDLE: begin
        if (start) begin
          state_n     = ST_RUN;
          busy_n      = 1'b1;
          count_n     = is_div(E_MDOp) ?
                        DIV_N : MULT_N;
          pend_hi_n   = res[63:32];
          pend_lo_n   = res[31:0];
          pend_keep_n = div0;
        end else if (E_MDOp == MD_MTHI) begin
          hi_n = E_A;
        end else if (E_MDOp == MD_MTLO) begin
          lo_n = E_A;
        end
      end
      ST_RUN: begin
        // Ops arriving here are ignored.
        count_n = count - CNT_W'(1);
        if (count == CNT_W'(1)) begin
          state_n = ST_IDLE;
          busy_n  = 1'b0;
          // Divide by zero leaves HI/LO as-is.
          if (!pend_keep) begin
            hi_n = pend_hi;
            lo_n = pend_lo;
          end
        end
      end
      default: begin
        state_n = ST_IDLE;
        busy_n  = 1'b0;
        count_n = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= ST_IDLE;
      count     <= '0;
      busy      <= 1'b0;
      hi        <= '0;
      lo        <= '0;
      pend_hi   <= '0;
      pend_lo   <= '0;
      pend_keep <= 1'b0;
    end else begin
      state     <= state_n;
      count     <= count_n;
      busy      <= busy_n;
      hi        <= hi_n;
      lo        <= lo_n;
      pend_hi   <= pend_hi_n;
      pend_lo   <= pend_lo_n;
      pend_keep <= pend_keep_n;
    end
  end

  a_no_op_while_busy: assert property (
    @(posedge clk) disable iff (!reset)
    !(busy && is_md(E_MDOp))
  ) else $error("md_ctrl: MDOp %0d while busy",
                E_MDOp);

endmodule

// File: tb/tb_md_ctrl.sv
// Directed self-checking bench for md_ctrl.
// Drives and samples on the falling edge, away from the active edge.
module tb_md_ctrl;
  import md_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  E_MDOp;
  logic [31:0] E_A;
  logic [31:0] E_B;
  logic        D_is_md;
  logic        start;
  logic        busy;
  logic        stall_md;
  logic [31:0] E_MDout;
  logic [31:0] hi;
  logic [31:0] lo;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  md_ctrl #(
    .MULT_CYCLES (5),
    .DIV_CYCLES  (10)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .E_MDOp   (E_MDOp),
    .E_A      (E_A),
    .E_B      (E_B),
    .D_is_md  (D_is_md),
    .start    (start),
    .busy     (busy),
    .stall_md (stall_md),
    .E_MDout  (E_MDout),
    .hi       (hi),
    .lo       (lo)
  );

  task automatic idle_in();
    E_MDOp = MD_NONE;
    E_A    = '0;
    E_B    = '0;
  endtask

  task automatic chk_hilo(
    input string       nm,
    input logic [31:0] eh,
    input logic [31:0] el
  );
    nvec++;
    if (hi !== eh || lo !== el) begin
      nerr++;
      $display("FAIL %s hilo: got %h/%h want %h/%h",
               nm, hi, lo, eh, el);
    end
  endtask

  // Issue op at cycle T, expect busy for n cycles,
  // then the committed result at T+n+1.
  task automatic run_op(
    input string       nm,
    input logic [3:0]  op,
    input logic [31:0] a,
    input logic [31:0] b,
    input int          n,
    input logic [31:0] eh,
    input logic [31:0] el
  );
    @(negedge clk);
    E_MDOp = op;
    E_A    = a;
    E_B    = b;
    #1;
    nvec++;
    if (start !== 1'b1 || busy !== 1'b0) begin
      nerr++;
      $display("FAIL %s start: start=%b busy=%b want 1 0",
               nm, start, busy);
    end
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      idle_in();
      #1;
      nvec++;
      if (busy !== 1'b1) begin
        nerr++;
        $display("FAIL %s busy T+%0d: got %b want 1",
                 nm, i, busy);
      end
    end
    @(negedge clk);
    #1;
    nvec++;
    if (busy !== 1'b0) begin
      nerr++;
      $display("FAIL %s done: busy=%b want 0",
               nm, busy);
    end
    chk_hilo(nm, eh, el);
  endtask

  task automatic test_reset();
    reset   = 1'b0;
    D_is_md = 1'b1;
    idle_in();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    #1;
    chk_hilo("reset", 32'd0, 32'd0);
    nvec++;
    if (busy !== 1'b0 || stall_md !== 1'b0) begin
      nerr++;
      $display("FAIL reset: busy=%b stall=%b want 0 0",
               busy, stall_md);
    end
    D_is_md = 1'b0;
  endtask

  task automatic test_mult();
    run_op("mult", MD_MULT, 32'hFFFF_FFFF,
           32'd2, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    run_op("multu", MD_MULTU, 32'hFFFF_FFFF,
           32'd2, 5, 32'h0000_0001, 32'hFFFF_FFFE);
  endtask

  task automatic test_div();
    run_op("div", MD_DIV, 32'hFFFF_FFF9,
           32'd2, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("divu", MD_DIVU, 32'd100,
           32'd7, 10, 32'd2, 32'd14);
    run_op("div_ovf", MD_DIV, 32'h8000_0000,
           32'hFFFF_FFFF, 10, 32'd0, 32'h8000_0000);
  endtask

  task automatic test_mt_div0();
    @(negedge clk);
    E_MDOp = MD_MTHI;
    E_A    = 32'h11;
    #1;
    nvec++;
    if (start !== 1'b0) begin
      nerr++;
      $display("FAIL mthi start: got %b want 0", start);
    end
    @(negedge clk);
    E_MDOp = MD_MTLO;
    E_A    = 32'h22;
    #1;
    nvec++;
    if (hi !== 32'h11 || busy !== 1'b0) begin
      nerr++;
      $display("FAIL mthi: hi=%h busy=%b want 11 0",
               hi, busy);
    end
    @(negedge clk);
    idle_in();
    #1;
    chk_hilo("mtlo", 32'h11, 32'h22);
    run_op("div0", MD_DIV, 32'd5, 32'd0, 10,
           32'h11, 32'h22);
    run_op("divu0", MD_DIVU, 32'd9, 32'd0, 10,
           32'h11, 32'h22);
  endtask

  task automatic test_bad_op();
    @(negedge clk);
    E_MDOp = 4'd12;
    E_A    = 32'hDEAD_BEEF;
    E_B    = 32'd3;
    #1;
    nvec++;
    if (start !== 1'b0 || E_MDout !== 32'd0) begin
      nerr++;
      $display("FAIL op12: start=%b out=%h want 0 0",
               start, E_MDout);
    end
    @(negedge clk);
    idle_in();
    #1;
    nvec++;
    if (busy !== 1'b0) begin
      nerr++;
      $display("FAIL op12 busy: got %b want 0", busy);
    end
    chk_hilo("op12", 32'h11, 32'h22);
  endtask

  task automatic test_stall();
    D_is_md = 1'b1;
    @(negedge clk);
    E_MDOp = MD_MULT;
    E_A    = 32'd3;
    E_B    = 32'd4;
    #1;
    for (int i = 0; i <= 5; i++) begin
      nvec++;
      if (stall_md !== 1'b1) begin
        nerr++;
        $display("FAIL stall T+%0d: got %b want 1",
                 i, stall_md);
      end
      @(negedge clk);
      idle_in();
      #1;
    end
    E_MDOp = MD_MFLO;
    #1;
    nvec++;
    if (stall_md !== 1'b0 || E_MDout !== 32'd12) begin
      nerr++;
      $display("FAIL stall end: stall=%b out=%h want 0 c",
               stall_md, E_MDout);
    end
    E_MDOp = MD_MFHI;
    #1;
    nvec++;
    if (E_MDout !== 32'd0) begin
      nerr++;
      $display("FAIL mfhi: got %h want 0", E_MDout);
    end
    D_is_md = 1'b0;
    @(negedge clk);
    idle_in();
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    E_MDOp = MD_MULT;
    E_A    = 32'd2;
    E_B    = 32'd3;
    repeat (5) begin
      @(negedge clk);
      idle_in();
    end
    // T+6: result visible and new start accepted.
    @(negedge clk);
    E_MDOp = MD_MULTU;
    E_A    = 32'd5;
    E_B    = 32'd5;
    #1;
    nvec++;
    if (start !== 1'b1 || lo !== 32'd6) begin
      nerr++;
      $display("FAIL b2b: start=%b lo=%h want 1 6",
               start, lo);
    end
    repeat (5) begin
      @(negedge clk);
      idle_in();
      #1;
      nvec++;
      if (busy !== 1'b1) begin
        nerr++;
        $display("FAIL b2b busy: got %b want 1", busy);
      end
    end
    @(negedge clk);
    #1;
    chk_hilo("b2b", 32'd0, 32'd25);
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    E_MDOp = MD_DIVU;
    E_A    = 32'd100;
    E_B    = 32'd7;
    repeat (2) begin
      @(negedge clk);
      idle_in();
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    nvec++;
    if (busy !== 1'b0 || start !== 1'b0) begin
      nerr++;
      $display("FAIL rst_mid: busy=%b start=%b want 0 0",
               busy, start);
    end
    chk_hilo("rst_mid", 32'd0, 32'd0);
    run_op("post_rst", MD_MULT, 32'd6, 32'd7, 5,
           32'd0, 32'd42);
  endtask

  initial begin
    reset   = 1'b0;
    D_is_md = 1'b0;
    idle_in();
    test_reset();
    test_mult();
    test_div();
    test_mt_div0();
    test_bad_op();
    test_stall();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

endmodule

// File: doc/md_ctrl.md
Name: md_ctrl

Overview:
- Multi-cycle multiply/divide controller for the five-stage pipeline; sits in E stage beside the ALU.
- Accepts mult/multu/div/divu/mthi/mtlo/mfhi/mflo from E, owns HI/LO, and models a fixed-latency busy window.
- Raises a stall request to the hazard unit when a D-stage HI/LO-using instruction would collide with an active or starting operation.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (1..15)
- DIV_CYCLES, 10, busy cycles for div/divu (1..15)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-low reset
- E_MDOp  in  4  E-stage op: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 mfhi, 8 mflo; 9-15 treated as none
- E_A  in  32  forwarded rs value (E_V1_f)
- E_B  in  32  forwarded rt value (E_V2_f)
- D_is_md  in  1  D-stage instruction is any MDOp 1-8
- start  out  1  combinational: E_MDOp in {1,2,3,4} and state IDLE
- busy  out  1  registered: operation in progress
- stall_md  out  1  combinational: D_is_md && (start || busy)
- E_MDout  out  32  combinational: HI when E_MDOp=7, LO when 8, else 0
- hi  out  32  HI register
- lo  out  32  LO register

Behaviour:
- Reset (reset==0 at rising edge): state=IDLE, count=0, busy=0, hi=0, lo=0, pending result=0. Reset mid-operation aborts it; no commit.
- FSM IDLE -> RUN on start: latch the 64-bit result from md_arith into pending_hi/pending_lo, set count=N (MULT_CYCLES or DIV_CYCLES), set busy=1.
- RUN: count decrements each cycle. When count==1: commit pending to hi/lo, clear busy, go to IDLE.
- Timing: op in E at cycle T. busy is high in cycles T+1..T+N. New hi/lo are visible in cycle T+N+1. busy is low in T+N+1.
- Back-to-back: a new start is accepted in cycle T+N+1.
- mult: signed 32x32->64, hi=[63:32], lo=[31:0]. multu: unsigned.
- div: signed, lo=quotient truncated toward zero, hi=remainder with the sign of the dividend. divu: unsigned.
- Divide by zero (E_B==0, op 3/4): the FSM runs the full DIV_CYCLES. hi/lo are left unchanged at commit.
- Signed overflow (0x80000000 / -1): lo=0x80000000, hi=0.
- mthi/mtlo in IDLE: write E_A to hi/lo at the clock edge, with 1-cycle visibility. No busy.
- Any MDOp arriving in E while busy is a protocol violation; the hazard unit prevents it. The block ignores the op (no state change) and a simulation assertion fires.
- mfhi/mflo read the current registers combinationally. The same-cycle commit is not forwarded; stall_md guarantees no overlap.
- E-stage bubble (E_MDOp=0) has no effect on a RUN in progress. Pipeline stalls do not pause count.

Decomposition:
- Shared package md_pkg holds:
  - MDOp localparams (MD_NONE..MD_MFLO)
  - FSM state encoding (ST_IDLE, ST_RUN)
  - count width (4)
- One sub-module, md_arith: purely combinational. Inputs are MDOp, A and B; outputs are the 64-bit {hi,lo} result and a div0 flag. md_ctrl owns all sequential state.

Test Plan:
- Reset then idle -> hi=lo=0, busy=0, stall_md=0 even with D_is_md=1.
- mult A=0xFFFFFFFF, B=2 at T -> busy T+1..T+5; at T+6 hi=0xFFFFFFFF, lo=0xFFFFFFFE. Same operands with multu -> hi=0x00000001, lo=0xFFFFFFFE.
- div A=0xFFFFFFF9 (-7), B=2 -> busy for 10 cycles; then lo=0xFFFFFFFD, hi=0xFFFFFFFF. divu 100/7 -> lo=14, hi=2.
- Preload hi=0x11, lo=0x22 via mthi/mtlo; then div by B=0 -> busy 10 cycles; afterwards hi=0x11, lo=0x22.
- Hold D_is_md=1 while mult starts and runs -> stall_md=1 from T through T+5, and 0 at T+6. mflo in E at T+6 returns the new lo on E_MDout.
- Assert reset at T+3 of a div -> at T+4 busy=0, hi=lo=0, state IDLE; a following mult completes normally.
